// File: rtl/gtfwizard_mac_drp_rmw_master.sv
// gtfwizard_mac_drp_rmw_master
//   AXI4-Lite master placed directly upstream of the GTF DRP bridge. Converts
//   per-channel DRP commands (read, write, read-modify-write) into AXI4-Lite
//   transactions, one command in flight at a time.
// Ports
//   s_axi_aclk / s_axi_aresetn : clock, asynchronous active-low reset
//   cmd_*   : command channel (valid/ready), op 00 rd, 01 wr, 10 rmw, 11 reserved
//   rsp_*   : response channel (valid/ready), read data and AXI resp code
//   err_count : saturating count of responses carrying a non-OKAY code
//   m_axi_* : AXI4-Lite master (32-bit address/data, 4-bit strobe)
module gtfwizard_mac_drp_rmw_master #(
  parameter int DRP_COUNT      = 4,
  parameter int DRP_ADDR_WIDTH = 9,
  parameter int DRP_DATA_WIDTH = 16,
  parameter int SEL_W          = (DRP_COUNT == 1) ? 1 : $clog2(DRP_COUNT)
) (
  input  logic                      s_axi_aclk,
  input  logic                      s_axi_aresetn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_op,
  input  logic [SEL_W-1:0]          cmd_sel,
  input  logic [DRP_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DRP_DATA_WIDTH-1:0] cmd_wdata,
  input  logic [DRP_DATA_WIDTH-1:0] cmd_mask,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DRP_DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]                rsp_err,
  output logic [15:0]               err_count,
  output logic [31:0]               m_axi_awaddr,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [31:0]               m_axi_wdata,
  output logic [3:0]                m_axi_wstrb,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic [31:0]               m_axi_araddr,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [31:0]               m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready
);

  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_RMW = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_AW, WR_B, RSP} state_t;

  state_t                    state_q, state_d;
  logic [1:0]                op_q;
  logic [SEL_W-1:0]          sel_q;
  logic [DRP_ADDR_WIDTH-1:0] addr_q;
  logic [DRP_DATA_WIDTH-1:0] mask_q;
  // Holds the write value: cmd_wdata on accept, replaced by the merged word
  // once the RMW read returns.
  logic [DRP_DATA_WIDTH-1:0] wr_val_q;
  logic                      aw_done, w_done;
  logic [31:0]               drp_addr;
  logic                      unused_rdata;

  assign unused_rdata = ^m_axi_rdata;

  always_comb begin
    drp_addr = '0;
    drp_addr[DRP_ADDR_WIDTH+1:2] = addr_q;
    if (DRP_COUNT > 1) drp_addr[DRP_ADDR_WIDTH+2 +: SEL_W] = sel_q;
  end

  assign m_axi_awaddr = drp_addr;
  assign m_axi_araddr = drp_addr;
  assign m_axi_wstrb  = 4'hF;

  always_comb begin
    m_axi_wdata = '0;
    m_axi_wdata[DRP_DATA_WIDTH-1:0] = wr_val_q;
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) state_q <= IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    cmd_ready     = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    rsp_valid     = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          case (cmd_op)
            OP_WR:   state_d = WR_AW;
            OP_RSV:  state_d = RSP;
            default: state_d = RD_A;
          endcase
        end
      end
      RD_A: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_d = RD_D;
      end
      RD_D: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid)
          state_d = (op_q == OP_RMW && m_axi_rresp == 2'b00) ? WR_AW : RSP;
      end
      WR_AW: begin
        // AW and W complete independently; leave once both have handshaken,
        // including the case where the last one completes this cycle.
        m_axi_awvalid = !aw_done;
        m_axi_wvalid  = !w_done;
        if ((aw_done || m_axi_awready) && (w_done || m_axi_wready)) state_d = WR_B;
      end
      WR_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_d = RSP;
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      op_q      <= '0;
      sel_q     <= '0;
      addr_q    <= '0;
      mask_q    <= '0;
      wr_val_q  <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= '0;
      err_count <= '0;
    end else begin
      if (state_q != WR_AW) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (m_axi_awready) aw_done <= 1'b1;
        if (m_axi_wready)  w_done  <= 1'b1;
      end
      case (state_q)
        IDLE: if (cmd_valid) begin
          op_q      <= cmd_op;
          sel_q     <= cmd_sel;
          addr_q    <= cmd_addr;
          mask_q    <= cmd_mask;
          wr_val_q  <= cmd_wdata;
          rsp_rdata <= '0;
          rsp_err   <= (cmd_op == OP_RSV) ? RESP_SLVERR : 2'b00;
        end
        RD_D: if (m_axi_rvalid) begin
          rsp_rdata <= m_axi_rdata[DRP_DATA_WIDTH-1:0];
          rsp_err   <= m_axi_rresp;
          if (op_q == OP_RMW)
            wr_val_q <= (m_axi_rdata[DRP_DATA_WIDTH-1:0] & ~mask_q) | (wr_val_q & mask_q);
        end
        WR_B: if (m_axi_bvalid) rsp_err <= m_axi_bresp;
        RSP: if (rsp_ready && rsp_err != 2'b00 && err_count != 16'hFFFF)
          err_count <= err_count + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gtfwizard_mac_drp_rmw_master.sv
// Testbench for gtfwizard_mac_drp_rmw_master: AXI4-Lite slave with
// programmable handshake delays, reference model of command results and
// timing, directed cases followed by randomized commands.
module tb_gtfwizard_mac_drp_rmw_master;
  localparam int DRP_COUNT = 4;
  localparam int AW        = 9;
  localparam int DW        = 16;
  localparam int SEL_W     = 2;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [SEL_W-1:0] cmd_sel = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0, cmd_mask = '0;
  logic rsp_valid;
  logic rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic [15:0] err_count;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr;
  logic m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
  logic [3:0] m_axi_wstrb;
  logic m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_arready = 1'b0;
  logic m_axi_bvalid = 1'b0, m_axi_rvalid = 1'b0;
  logic [1:0] m_axi_bresp = '0, m_axi_rresp = '0;
  logic [31:0] m_axi_rdata = '0;

  gtfwizard_mac_drp_rmw_master #(
    .DRP_COUNT(DRP_COUNT), .DRP_ADDR_WIDTH(AW), .DRP_DATA_WIDTH(DW)
  ) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_sel(cmd_sel),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .err_count(err_count),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int model_errs = 0;

  // Slave configuration, set by the stimulus before each command.
  int ar_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  logic [DW-1:0] s_rdata = '0;
  logic [1:0] s_rresp = '0, s_bresp = '0;

  // Bus monitor: handshake counts, valid-high cycle counts, captured beats.
  int ar_hs_n = 0, aw_hs_n = 0, w_hs_n = 0, r_hs_n = 0, b_hs_n = 0;
  int ar_vcyc = 0, aw_vcyc = 0, w_vcyc = 0;
  logic [31:0] last_araddr = '0, last_awaddr = '0, last_wdata = '0;
  logic [3:0] last_wstrb = '0;

  always @(posedge clk) begin
    if (m_axi_arvalid) ar_vcyc++;
    if (m_axi_awvalid) aw_vcyc++;
    if (m_axi_wvalid)  w_vcyc++;
    if (m_axi_arvalid && m_axi_arready) begin ar_hs_n++; last_araddr = m_axi_araddr; end
    if (m_axi_awvalid && m_axi_awready) begin aw_hs_n++; last_awaddr = m_axi_awaddr; end
    if (m_axi_wvalid && m_axi_wready) begin
      w_hs_n++; last_wdata = m_axi_wdata; last_wstrb = m_axi_wstrb;
    end
    if (m_axi_rvalid && m_axi_rready) r_hs_n++;
    if (m_axi_bvalid && m_axi_bready) b_hs_n++;
  end

  // Slave: drives its outputs on the falling edge from the monitor's counts.
  int ar_w = 0, aw_w = 0, w_w = 0, b_w = 0, r_iss = 0, b_iss = 0, r_mark = 0, b_mark = 0;
  int wr_pairs;
  always @(negedge clk) begin
    wr_pairs = (aw_hs_n < w_hs_n) ? aw_hs_n : w_hs_n;
    if (!aresetn) begin
      m_axi_arready = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
      m_axi_rvalid = 1'b0; m_axi_bvalid = 1'b0;
      ar_w = 0; aw_w = 0; w_w = 0; b_w = 0;
      r_iss = ar_hs_n; b_iss = wr_pairs;
    end else begin
      if (m_axi_arvalid) begin
        if (ar_w >= ar_dly) m_axi_arready = 1'b1; else begin m_axi_arready = 1'b0; ar_w++; end
      end else begin m_axi_arready = 1'b0; ar_w = 0; end
      if (m_axi_awvalid) begin
        if (aw_w >= aw_dly) m_axi_awready = 1'b1; else begin m_axi_awready = 1'b0; aw_w++; end
      end else begin m_axi_awready = 1'b0; aw_w = 0; end
      if (m_axi_wvalid) begin
        if (w_w >= w_dly) m_axi_wready = 1'b1; else begin m_axi_wready = 1'b0; w_w++; end
      end else begin m_axi_wready = 1'b0; w_w = 0; end
      if (m_axi_rvalid && r_hs_n != r_mark) m_axi_rvalid = 1'b0;
      if (!m_axi_rvalid && ar_hs_n > r_iss) begin
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = {16'($urandom), s_rdata};
        m_axi_rresp  = s_rresp;
        r_iss++; r_mark = r_hs_n;
      end
      if (m_axi_bvalid && b_hs_n != b_mark) m_axi_bvalid = 1'b0;
      if (!m_axi_bvalid && wr_pairs > b_iss) begin
        if (b_w >= b_dly) begin
          m_axi_bvalid = 1'b1; m_axi_bresp = s_bresp;
          b_iss++; b_mark = b_hs_n; b_w = 0;
        end else b_w++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  int d_awv, d_wv, d_b;

  // Issues one command and checks the response, bus activity and latency
  // against results derived from the command semantics.
  task automatic run_cmd(input string nm, input int op, input int sel, input int addr,
                         input int wdata, input int mask, input int rdval, input int rresp,
                         input int bresp, input int hold);
    int exp_err, exp_rd, exp_wd, exp_lat, lat, wmax;
    int a0, aw0, w0, b0, awv0, wv0;
    bit rd_iss, wr_iss;
    logic [31:0] exp_addr;
    s_rdata = 16'(rdval); s_rresp = 2'(rresp); s_bresp = 2'(bresp);
    exp_addr = 32'(sel) * 32'(1 << (AW + 2)) + 32'(addr) * 32'd4;
    rd_iss = (op == 0 || op == 2);
    wr_iss = (op == 1) || (op == 2 && rresp == 0);
    if (op == 3)      exp_err = 2;
    else if (op == 0) exp_err = rresp;
    else if (op == 1) exp_err = bresp;
    else              exp_err = (rresp != 0) ? rresp : bresp;
    exp_rd = rd_iss ? rdval : 0;
    exp_wd = (op == 1) ? wdata : (((rdval & ~mask) | (wdata & mask)) & 32'hFFFF);
    wmax = (aw_dly > w_dly) ? aw_dly : w_dly;
    if (op == 3)                       exp_lat = 1;
    else if (op == 0)                  exp_lat = 3 + ar_dly;
    else if (op == 1)                  exp_lat = 3 + wmax + b_dly;
    else if (rresp != 0)               exp_lat = 3 + ar_dly;
    else                               exp_lat = 5 + ar_dly + wmax + b_dly;
    if (exp_err != 0 && model_errs < 65535) model_errs++;
    a0 = ar_hs_n; aw0 = aw_hs_n; w0 = w_hs_n; b0 = b_hs_n; awv0 = aw_vcyc; wv0 = w_vcyc;

    @(negedge clk);
    chk({nm, "_cmd_ready_idle"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = 2'(op); cmd_sel = 2'(sel); cmd_addr = 9'(addr);
    cmd_wdata = 16'(wdata); cmd_mask = 16'(mask);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_sel = 2'($urandom);
    cmd_addr = 9'($urandom); cmd_wdata = 16'($urandom); cmd_mask = 16'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 300) begin @(negedge clk); lat++; end
    chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_rsp_rdata"}, 32'(rsp_rdata), 32'(exp_rd));
    chk({nm, "_rsp_err"}, 32'(rsp_err), 32'(exp_err));
    chk({nm, "_cmd_ready_busy"}, 32'(cmd_ready), 32'd0);
    repeat (hold) begin
      @(negedge clk);
      chk({nm, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({nm, "_hold_rdata"}, 32'(rsp_rdata), 32'(exp_rd));
      chk({nm, "_hold_err"}, 32'(rsp_err), 32'(exp_err));
      chk({nm, "_hold_cmd_ready"}, 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({nm, "_rsp_done"}, 32'(rsp_valid), 32'd0);
    chk({nm, "_cmd_ready_back"}, 32'(cmd_ready), 32'd1);
    chk({nm, "_err_count"}, 32'(err_count), 32'(model_errs));
    chk({nm, "_ar_beats"}, 32'(ar_hs_n - a0), 32'(rd_iss));
    chk({nm, "_aw_beats"}, 32'(aw_hs_n - aw0), 32'(wr_iss));
    chk({nm, "_w_beats"}, 32'(w_hs_n - w0), 32'(wr_iss));
    chk({nm, "_b_beats"}, 32'(b_hs_n - b0), 32'(wr_iss));
    if (rd_iss) chk({nm, "_araddr"}, last_araddr, exp_addr);
    if (wr_iss) begin
      chk({nm, "_awaddr"}, last_awaddr, exp_addr);
      chk({nm, "_wdata"}, last_wdata, 32'(exp_wd));
      chk({nm, "_wstrb"}, 32'(last_wstrb), 32'hF);
    end
    d_awv = aw_vcyc - awv0; d_wv = w_vcyc - wv0; d_b = b_hs_n - b0;
  endtask

  int arv0, awv0, wv0, b0, wait_n;
  int op, rr, br;

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_arvalid", 32'(m_axi_arvalid), 32'd0);
    chk("rst_awvalid", 32'(m_axi_awvalid), 32'd0);
    chk("rst_wvalid", 32'(m_axi_wvalid), 32'd0);
    chk("rst_readies", 32'({m_axi_bready, m_axi_rready}), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    aresetn = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Read of channel 2 and channel 1, always-ready slave.
    run_cmd("rd_ch2", 0, 2, 'h07C, 0, 0, 'h1234, 0, 0, 0);
    chk("rd_ch2_no_aw", 32'(d_awv), 32'd0);
    run_cmd("rd_ch1", 0, 1, 'h07C, 0, 0, 'h5A5A, 0, 0, 0);
    chk("rd_ch1_araddr_lit", last_araddr, 32'h0000_09F0);

    // Read-modify-write merge.
    run_cmd("rmw_ok", 2, 1, 'h010, 'h0050, 'h00F0, 'hABCD, 0, 0, 1);
    chk("rmw_ok_wdata_lit", last_wdata, 32'h0000_AB5D);

    // Write with AW stalled three cycles, W immediately accepted.
    aw_dly = 3;
    run_cmd("wr_awstall", 1, 3, 'h1FF, 'hC3C3, 0, 0, 0, 0, 0);
    chk("wr_awstall_awvalid_cycles", 32'(d_awv), 32'd4);
    chk("wr_awstall_wvalid_cycles", 32'(d_wv), 32'd1);
    chk("wr_awstall_b_beats", 32'(d_b), 32'd1);
    aw_dly = 0;

    // RMW whose read fails: write phase skipped, error counted.
    chk("rmw_err_count_before", 32'(err_count), 32'd0);
    run_cmd("rmw_rderr", 2, 0, 'h020, 'hFFFF, 'hFFFF, 'h1111, 2, 0, 0);
    chk("rmw_err_count_after", 32'(err_count), 32'd1);

    // Reserved opcode, response held back for five cycles.
    arv0 = ar_vcyc; awv0 = aw_vcyc; wv0 = w_vcyc;
    run_cmd("op_rsv", 3, 1, 'h055, 'h1234, 'hFFFF, 0, 0, 0, 5);
    chk("op_rsv_no_valids", 32'((ar_vcyc - arv0) + (aw_vcyc - awv0) + (wv0 - w_vcyc)), 32'd0);

    // Reset while waiting for the write response.
    b_dly = 20;
    b0 = b_hs_n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_sel = 2'd2; cmd_addr = 9'h0AA; cmd_wdata = 16'hBEEF;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_n = 0;
    while (!m_axi_bready && wait_n < 30) begin @(negedge clk); wait_n++; end
    chk("midrst_reached_wr_b", 32'(m_axi_bready), 32'd1);
    aresetn = 1'b0;
    #1;
    chk("midrst_valids", 32'({m_axi_arvalid, m_axi_awvalid, m_axi_wvalid}), 32'd0);
    chk("midrst_readies", 32'({m_axi_bready, m_axi_rready}), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_err_count", 32'(err_count), 32'd0);
    chk("midrst_rsp_err", 32'(rsp_err), 32'd0);
    model_errs = 0;
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    b_dly = 0;
    @(negedge clk);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (4) begin
      @(negedge clk);
      chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    chk("midrst_no_b", 32'(b_hs_n - b0), 32'd0);

    // Randomized commands with random slave timing and response codes.
    for (int i = 0; i < 40; i++) begin
      ar_dly = int'($urandom_range(0, 3));
      aw_dly = int'($urandom_range(0, 3));
      w_dly  = int'($urandom_range(0, 3));
      b_dly  = int'($urandom_range(0, 3));
      op = int'($urandom_range(0, 3));
      rr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      br = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_cmd($sformatf("rnd%0d", i), op, int'($urandom_range(0, 3)),
              int'($urandom_range(0, 511)), int'($urandom_range(0, 65535)),
              int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
              rr, br, int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
